// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator state encoding and key-code field mapping.
// Also imported by the scanner/decoder side, so the code-to-row/column mapping lives only here.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } emu_state_t;

  localparam int unsigned KEY_ROW_MSB = 3;
  localparam int unsigned KEY_ROW_LSB = 2;
  localparam int unsigned KEY_COL_MSB = 1;
  localparam int unsigned KEY_COL_LSB = 0;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[KEY_ROW_MSB:KEY_ROW_LSB];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[KEY_COL_MSB:KEY_COL_LSB];
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/emu_timer.sv
// Loadable down-counter shared by every timed emulator state; tc flags the last cycle (count==1).
module emu_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: closes one switch per accepted request and reflects the row onto its column.
// Optional contact bounce on make/break is enabled by defining KEYPAD_EMULATOR_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned BOUNCE_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       busy,
  output logic       key_seen,
  output logic       done
);

  localparam int unsigned CMAX = max3(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES);
  localparam int unsigned CW   = $clog2(CMAX + 1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_bad_params
    $error("keypad_emulator: all timing parameters must be at least 1");
  end

  emu_state_t    state;
  logic          contact;
  logic [3:0]    key_q;
  logic          accept;
  logic          row_hit;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  assign key_ready = (state == ST_IDLE);
  assign busy      = !key_ready;
  assign accept    = key_valid && key_ready;
  assign row_hit   = row_in[key_row(key_q)];
  assign done      = (state == ST_GAP) && tmr_tc;

  // Zero-latency contact path: the scanner sees the row come straight back, unsynchronized.
  always_comb begin
    col_out                 = '0;
    col_out[key_col(key_q)] = contact && row_hit;
  end

  // Timer is reloaded on every state entry with the duration of the state being entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
      ST_IDLE:       begin tmr_load = accept; tmr_val = CW'(BOUNCE_CYCLES); end
      ST_BOUNCE_IN:  begin tmr_load = tmr_tc; tmr_val = CW'(HOLD_CYCLES);   end
      ST_HOLD:       begin tmr_load = tmr_tc; tmr_val = CW'(BOUNCE_CYCLES); end
      ST_BOUNCE_OUT: begin tmr_load = tmr_tc; tmr_val = CW'(GAP_CYCLES);    end
`else
      ST_IDLE:       begin tmr_load = accept; tmr_val = CW'(HOLD_CYCLES);   end
      ST_HOLD:       begin tmr_load = tmr_tc; tmr_val = CW'(GAP_CYCLES);    end
`endif
      default: ;
    endcase
  end

  emu_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int unsigned PW = $clog2(BOUNCE_PERIOD + 1);
  logic [PW-1:0] phase;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      contact  <= 1'b0;
      key_q    <= '0;
      key_seen <= 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
      phase    <= '0;
`endif
    end else begin
      if ((state == ST_HOLD || state == ST_BOUNCE_IN) && contact && row_hit) begin
        key_seen <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            key_q    <= key_code;
            key_seen <= 1'b0;
            contact  <= 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            state    <= ST_BOUNCE_IN;
            phase    <= PW'(BOUNCE_PERIOD);
`else
            state    <= ST_HOLD;
`endif
          end
        end
        ST_HOLD: begin
          if (tmr_tc) begin
            contact <= 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            state   <= ST_BOUNCE_OUT;
            phase   <= PW'(BOUNCE_PERIOD);
`else
            state   <= ST_GAP;
`endif
          end
        end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
          if (tmr_tc) begin
            contact <= (state == ST_BOUNCE_IN);
            state   <= (state == ST_BOUNCE_IN) ? ST_HOLD : ST_GAP;
          end else if (phase == PW'(1)) begin
            contact <= !contact;
            phase   <= PW'(BOUNCE_PERIOD);
          end else begin
            phase   <= phase - PW'(1);
          end
        end
`endif
        ST_GAP: begin
          if (tmr_tc) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator (HOLD=8, GAP=4, BOUNCE=4, PERIOD=2); bounce sequence only when KEYPAD_EMULATOR_BOUNCE_EN is defined.
module tb_keypad_emulator;
  import keypad_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       busy;
  logic       key_seen;
  logic       done;

  keypad_emulator #(
    .HOLD_CYCLES   (8),
    .GAP_CYCLES    (4),
    .BOUNCE_CYCLES (4),
    .BOUNCE_PERIOD (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .row_in    (row_in),
    .col_out   (col_out),
    .busy      (busy),
    .key_seen  (key_seen),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] col;
    logic       rdy;
    logic       dn;
    logic       seen_en;
    logic       seen;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (col_out !== e.col || key_ready !== e.rdy || busy !== !e.rdy || done !== e.dn ||
          (e.seen_en && key_seen !== e.seen)) begin
        errors++;
        $display("FAIL %s: got col_out=%b key_ready=%b busy=%b done=%b key_seen=%b, expected col_out=%b key_ready=%b busy=%b done=%b key_seen=%b",
                 e.name, col_out, key_ready, busy, done, key_seen,
                 e.col, e.rdy, !e.rdy, e.dn, e.seen_en ? e.seen : key_seen);
      end
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic [3:0] ri, input logic kv,
                     input logic [3:0] kc, input logic [3:0] ecol, input logic erdy,
                     input logic edn, input logic esen, input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    row_in    = ri;
    key_valid = kv;
    key_code  = kc;
    e.name = nm; e.col = ecol; e.rdy = erdy; e.dn = edn; e.seen_en = esen; e.seen = es;
    q.push_back(e);
  endtask

  // One full press, k=0 is the accept cycle; optionally a stray request at busy_k and a
  // new request presented in the done cycle (chain), which must only be taken a cycle later.
  task automatic press(input string nm, input logic [3:0] code, input bit rot,
                       input logic [3:0] rp, input int busy_k, input bit chain,
                       input logic [3:0] ncode);
    int         r;
    int         c;
    bit         seen;
    bit         hold;
    logic [3:0] ri;
    logic       kv;
    logic [3:0] kc;
    logic [3:0] ecol;
    r    = int'(code[3:2]);
    c    = int'(code[1:0]);
    seen = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      ri   = rot ? 4'(1 << (k % 4)) : rp;
      kv   = (k == 0) || (k == busy_k) || (chain && k == 12);
      kc   = (k == 0) ? code : ((k == busy_k) ? 4'hF : ncode);
      hold = (k >= 1 && k <= 8);
      ecol = (hold && ri[r]) ? 4'(1 << c) : 4'b0000;
      cyc($sformatf("%s_k%0d", nm, k), 1'b1, ri, kv, kc, ecol, k == 0, k == 12, k != 0, seen);
      if (hold && ri[r]) seen = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] pats [4];
    pats[0] = 4'b0000; pats[1] = 4'b1111; pats[2] = 4'b0101; pats[3] = 4'b1010;
    reset = 1'b0; row_in = '0; key_valid = 1'b0; key_code = '0;

    cyc("in_reset", 1'b0, 4'b1111, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("idle_row%0d", i), 1'b1, pats[i], 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    begin
      logic [20:0] bpat;
      bpat = 21'b000000011111111110011_0 >> 1;
      // k=1..20 col_out[0]: 1,1,0,0, 8x1, 0,0,1,1, 4x0
      bpat = '0;
      bpat[1] = 1; bpat[2] = 1;
      for (int k = 5; k <= 12; k++) bpat[k] = 1'b1;
      bpat[15] = 1; bpat[16] = 1;
      for (int k = 0; k <= 20; k++)
        cyc($sformatf("bounce_k%0d", k), 1'b1, 4'b0001, k == 0, 4'h0, {3'b000, bpat[k]},
            k == 0, k == 20, k >= 2, 1'b1);
      cyc("bounce_ready", 1'b1, 4'b0001, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    end
`else
    press("held", 4'b0110, 1'b0, 4'b0010, -1, 1'b0, 4'h0);
    press("rot", 4'b0110, 1'b1, 4'b0000, -1, 1'b0, 4'h0);
    press("busyreq", 4'b0110, 1'b0, 4'b1111, 3, 1'b1, 4'b0001);
    press("chained", 4'b0001, 1'b0, 4'b1111, -1, 1'b0, 4'h0);
    cyc("sticky_idle", 1'b1, 4'b1111, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

    cyc("rstmid_acc", 1'b1, 4'b1111, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++)
      cyc($sformatf("rstmid_k%0d", k), 1'b1, 4'b1111, 1'b0, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rstmid_assert", 1'b0, 4'b1111, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rstmid_release", 1'b1, 4'b1111, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    press("after_rst", 4'b0110, 1'b0, 4'b0010, -1, 1'b0, 4'h0);
    cyc("final_idle", 1'b1, 4'b0010, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural-synthesizable model of a 4x4 matrix keypad: the passive end of the row-scan/column-sense interface.
- Accepts key-press requests over a valid/ready handshake and closes the matching switch for a programmed hold time.
- While the switch is closed, reflects the driven row onto the matching column, exactly as a physical contact does.
- Used in benches and on-board loopback to drive the keypad scanner without a physical keypad.

Parameters:
- HOLD_CYCLES, 64, cycles the contact stays closed (min 1)
- GAP_CYCLES, 16, cycles the contact stays open after release before the next request is accepted (min 1)
- BOUNCE_CYCLES, 8, length of each bounce window; used only with the optional feature (min 1)
- BOUNCE_PERIOD, 2, cycles per contact toggle inside a bounce window (min 1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- key_code  input  4  requested key: [3:2] row index, [1:0] column index
- key_valid  input  1  request strobe
- key_ready  output  1  emulator idle; request accepted when key_valid && key_ready
- row_in  input  4  row drive from scanner, active-high; more than one row may be high
- col_out  output  4  column sense to scanner, active-high
- busy  output  1  press sequence in progress
- key_seen  output  1  sticky: the pressed key's row was driven while the contact was closed
- done  output  1  one-cycle pulse at end of GAP

Behaviour:
- Reset (async, reset=0): state IDLE, contact open, key register 0, counter 0, key_seen 0, done 0. Because col_out is combinational from contact, col_out is 0 immediately. key_ready=1, busy=0.
- col_out is combinational, with zero latency from row_in:
  - col_out[c] = contact && row_in[r], where r and c are the latched row and column.
  - All other column bits are 0.
  - No synchronizer; the scanner owns synchronization.
- Handshake:
  - key_ready = (state==IDLE).
  - On accept, key_code is latched, key_seen is cleared, and the FSM leaves IDLE on the next edge.
  - key_valid while busy is ignored; no queueing.
- States (counter loaded on each entry, transition when counter reaches 1):
  - IDLE: contact open. On accept -> HOLD (or BOUNCE_IN when the feature is enabled).
  - HOLD: contact closed for exactly HOLD_CYCLES cycles -> GAP (or BOUNCE_OUT).
  - GAP: contact open for GAP_CYCLES cycles. done=1 in the final GAP cycle, then -> IDLE.
- Timing: with the feature disabled, the contact closes on the first edge after accept and col_out can respond that cycle. The accept-to-ready interval is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- key_seen: set on any cycle where the state is HOLD and row_in[r]=1. Holds through GAP and IDLE until the next accept.
- busy = !key_ready.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)+1).
- Simultaneous events:
  - A request arriving in the same cycle as the done pulse is not accepted (ready is still 0). It is accepted on the next cycle.
  - Reset asserted mid-press opens the contact instantly and discards the latched key.
- Ghosting: multiple simultaneous keys are out of scope; one key is modelled at a time.

Optional Feature:
- Macro: KEYPAD_EMULATOR_BOUNCE_EN
- Defined:
  - States BOUNCE_IN and BOUNCE_OUT exist, each lasting BOUNCE_CYCLES.
  - The contact toggles every BOUNCE_PERIOD cycles, starting closed in BOUNCE_IN and open in BOUNCE_OUT.
  - BOUNCE_OUT is followed by GAP.
  - key_seen is also set during BOUNCE_IN when the contact is closed and row_in[r]=1.
- Undefined: the bounce states, their logic and the bounce parameters' effect are absent, giving a clean make/break.

Decomposition:
- Shared package keypad_pkg:
  - state enum emu_state_t
  - key-code field positions KEY_ROW_MSB/LSB and KEY_COL_MSB/LSB
  - functions key_row() and key_col()
  - The scanner/decoder side uses the same package so code mapping is defined once.
- One sub-module, emu_timer: loadable down-counter with a terminal-count output, reused for every timed state.

Test Plan (HOLD=8, GAP=4, BOUNCE=4, PERIOD=2):
- Reset release, no request -> key_ready=1, busy=0, col_out=0 for any row_in pattern.
- Request key_code=4'b0110 (row1, col2) with row_in=4'b0010 held:
  - col_out=4'b0100 for exactly 8 cycles starting the cycle after accept.
  - Then 0; done pulses 4 cycles later; key_ready returns 13 cycles after accept.
- Same request with row_in rotating one-hot each cycle:
  - col_out=4'b0100 only in cycles where row_in[1]=1 during HOLD.
  - key_seen=1 after the first such cycle.
- Request while busy (key_valid=1 at cycle 3 of HOLD, code 4'hF) -> ignored; col_out never shows col3; latched key unchanged.
- Reset driven low at HOLD cycle 5 with row_in=4'b1111 -> col_out=0 in the same cycle; key_ready=1 after release.
- With KEYPAD_EMULATOR_BOUNCE_EN and row_in=4'b0001, key 4'h0 -> col_out[0] pattern: 1,1,0,0 ×2 cycles, then 8×1, then 0,0,1,1, then 4×0, then done.
